// File: rtl/bisr_ws_systolic_core_pkg.sv
// rtl/bisr_ws_systolic_core_pkg.sv - shared FSM states, self-test constants and default sizes
package bisr_core_pkg;

  localparam int DEF_ROWS      = 4;
  localparam int DEF_COLS      = 4;
  localparam int DEF_WORD_SIZE = 16;

  localparam int STW_OP1    = 4;
  localparam int STW_OP2    = 3;
  localparam int STW_ADD    = 1;
  localparam int STW_EXPECT = 13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STW_RUN,
    S_STW_CHECK,
    S_READY,
    S_LOAD_W,
    S_LOAD_IN,
    S_COMPUTE,
    S_WRITE
  } state_t;

endpackage

// File: rtl/bisr_ws_systolic_core_if.sv
// rtl/bisr_ws_systolic_core_if.sv - input/output memory bus between the core (master) and the RAMs (slave)
interface bisr_ws_systolic_core_if #(
  parameter int MEM_PORT_WIDTH = 64
) ();

  logic [MEM_PORT_WIDTH-1:0] mem_rd_data;
  logic [31:0]               mem_addr;
  logic                      mem_wr_en;
  logic [MEM_PORT_WIDTH-1:0] output_mem_wr_data;
  logic [31:0]               output_mem_addr;
  logic                      output_mem_wr_en;

  modport master (
    input  mem_rd_data,
    output mem_addr, mem_wr_en,
    output output_mem_wr_data, output_mem_addr, output_mem_wr_en
  );

  modport slave (
    output mem_rd_data,
    input  mem_addr, mem_wr_en,
    input  output_mem_wr_data, output_mem_addr, output_mem_wr_en
  );

endinterface

// File: rtl/bisr_ws_systolic_core_pe.sv
// rtl/bisr_ws_systolic_core_pe.sv - bisr_ws_pe: one weight-stationary MAC with self-test operand
// override and a stuck-at hook on its partial-sum output.
module bisr_ws_pe
  import bisr_core_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load_w,
  input  logic [WORD_SIZE-1:0] i_weight,
  input  logic                 i_stw,
  input  logic [WORD_SIZE-1:0] i_left,
  input  logic [WORD_SIZE-1:0] i_psum,
  input  logic                 i_fault_en,
  input  logic                 i_fault_val,
  output logic [WORD_SIZE-1:0] o_left,
  output logic [WORD_SIZE-1:0] o_psum
);

  logic [WORD_SIZE-1:0] r_weight;
  logic [WORD_SIZE-1:0] r_left;
  logic [WORD_SIZE-1:0] r_psum;
  logic [WORD_SIZE-1:0] w_a;
  logic [WORD_SIZE-1:0] w_w;
  logic [WORD_SIZE-1:0] w_p;
  logic [WORD_SIZE-1:0] w_mac;

  // Self-test swaps in fixed operands so the stored weight survives the test.
  assign w_a   = i_stw ? WORD_SIZE'(STW_OP1) : i_left;
  assign w_w   = i_stw ? WORD_SIZE'(STW_OP2) : r_weight;
  assign w_p   = i_stw ? WORD_SIZE'(STW_ADD) : i_psum;
  assign w_mac = w_p + w_a * w_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_weight <= '0;
      r_left   <= '0;
      r_psum   <= '0;
    end else begin
      if (i_load_w) r_weight <= i_weight;
      r_left <= i_left;
      r_psum <= i_fault_en ? {WORD_SIZE{i_fault_val}} : w_mac;
    end
  end

  assign o_left = r_left;
  assign o_psum = r_psum;

endmodule

// File: rtl/bisr_ws_systolic_core.sv
// rtl/bisr_ws_systolic_core.sv - weight-stationary systolic matmul with stop-the-world PE self-test.
// Optional self-test and fault injection enabled by macro BISR_STW_EN.
module bisr_ws_systolic_core
  import bisr_core_pkg::*;
#(
  parameter int ROWS           = DEF_ROWS,
  parameter int COLS           = DEF_COLS,
  parameter int WORD_SIZE      = DEF_WORD_SIZE,
  parameter int MEM_PORT_WIDTH = COLS * WORD_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inputs_rdy,
  input  logic                   start_fsm,
  input  logic                   start_matmul,
  output logic                   fsm_rdy,
  output logic                   STW_complete,
  output logic [ROWS*COLS-1:0]   STW_result_mat,
`ifdef BISR_STW_EN
  input  logic [ROWS*COLS*2-1:0] fault_inject_bus,
`endif
  bisr_ws_systolic_core_if.master mem_if
);

  localparam int COMPUTE_CYCLES = 2 * ROWS + COLS - 1;
  localparam int CNT_W          = $clog2(COMPUTE_CYCLES) + 1;
  localparam int IDX_W          = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [31:0]               r_mem_addr;
  logic [31:0]               r_out_addr;
  logic                      r_out_wr_en;
  logic [MEM_PORT_WIDTH-1:0] r_out_data;
  logic                      r_fsm_rdy;
  logic                      r_rd_vld;
  logic                      r_rd_left;
  logic [IDX_W-1:0]          r_rd_row;
  logic [MEM_PORT_WIDTH-1:0] r_left_buf [ROWS];
  logic [WORD_SIZE-1:0]      r_out_buf  [ROWS][COLS];

  logic [WORD_SIZE-1:0]      w_left_in [ROWS];
  logic [WORD_SIZE-1:0]      w_left    [ROWS][COLS];
  logic [WORD_SIZE-1:0]      w_psum    [ROWS][COLS];
  logic [ROWS-1:0]           w_load_w;
  logic                      w_stw;
  logic [ROWS*COLS-1:0]      w_fault_en;
  logic [ROWS*COLS-1:0]      w_fault_val;

`ifdef BISR_STW_EN
  assign w_stw = (r_state == S_STW_RUN);
  always_comb begin
    w_fault_en  = '0;
    w_fault_val = '0;
    for (int i = 0; i < ROWS * COLS; i++) begin
      w_fault_en[i]  = fault_inject_bus[2*i];
      w_fault_val[i] = fault_inject_bus[2*i+1];
    end
  end
`else
  assign w_stw       = 1'b0;
  assign w_fault_en  = '0;
  assign w_fault_val = '0;
`endif

  // Row r is skewed by r cycles so each LEFT row meets its partial sums on the diagonal.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      w_left_in[r] = '0;
      if (r_state == S_COMPUTE && r_cnt >= CNT_W'(r) && r_cnt < CNT_W'(r + ROWS))
        w_left_in[r] = r_left_buf[IDX_W'(r_cnt - CNT_W'(r))][r*WORD_SIZE +: WORD_SIZE];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign w_load_w[r] = r_rd_vld && !r_rd_left && (r_rd_row == IDX_W'(r));
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [WORD_SIZE-1:0] w_pe_left;
      logic [WORD_SIZE-1:0] w_pe_psum;
      if (c == 0) begin : g_left_edge
        assign w_pe_left = w_left_in[r];
      end else begin : g_left_pass
        assign w_pe_left = w_left[r][c-1];
      end
      if (r == 0) begin : g_psum_top
        assign w_pe_psum = '0;
      end else begin : g_psum_pass
        assign w_pe_psum = w_psum[r-1][c];
      end
      bisr_ws_pe #(.WORD_SIZE(WORD_SIZE)) u_pe (
        .clk         (clk),
        .rst         (rst),
        .i_load_w    (w_load_w[r]),
        .i_weight    (mem_if.mem_rd_data[c*WORD_SIZE +: WORD_SIZE]),
        .i_stw       (w_stw),
        .i_left      (w_pe_left),
        .i_psum      (w_pe_psum),
        .i_fault_en  (w_fault_en[c*ROWS+r]),
        .i_fault_val (w_fault_val[c*ROWS+r]),
        .o_left      (w_left[r][c]),
        .o_psum      (w_psum[r][c])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_out_addr  <= '0;
      r_out_wr_en <= 1'b0;
      r_out_data  <= '0;
      r_fsm_rdy   <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_rd_left   <= 1'b0;
      r_rd_row    <= '0;
      for (int i = 0; i < ROWS; i++) begin
        r_left_buf[i] <= '0;
        for (int c = 0; c < COLS; c++) r_out_buf[i][c] <= '0;
      end
    end else begin
      r_rd_vld <= 1'b0;
      if (r_rd_vld && r_rd_left) r_left_buf[r_rd_row] <= mem_if.mem_rd_data;
      case (r_state)
        S_IDLE: begin
          if (start_fsm) begin
`ifdef BISR_STW_EN
            r_state <= S_STW_RUN;
`else
            r_state   <= S_READY;
            r_fsm_rdy <= 1'b1;
`endif
          end
        end
        S_STW_RUN:   r_state <= S_STW_CHECK;
        S_STW_CHECK: begin
          r_state   <= S_READY;
          r_fsm_rdy <= 1'b1;
        end
        S_READY: begin
          if (start_matmul && inputs_rdy) begin
            r_fsm_rdy  <= 1'b0;
            r_state    <= S_LOAD_W;
            r_cnt      <= '0;
            r_mem_addr <= '0;
          end
        end
        S_LOAD_W, S_LOAD_IN: begin
          // Tag each issued address so its data is routed when it returns next cycle.
          r_rd_vld   <= 1'b1;
          r_rd_left  <= (r_state == S_LOAD_IN);
          r_rd_row   <= IDX_W'(r_cnt);
          r_mem_addr <= r_mem_addr + 32'd1;
          if (r_cnt == CNT_W'(ROWS - 1)) begin
            r_cnt <= '0;
            if (r_state == S_LOAD_W) begin
              r_state <= S_LOAD_IN;
            end else begin
              r_state    <= S_COMPUTE;
              r_mem_addr <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_COMPUTE: begin
          for (int c = 0; c < COLS; c++) begin
            if (r_cnt >= CNT_W'(ROWS + c) && r_cnt < CNT_W'(2 * ROWS + c))
              r_out_buf[IDX_W'(r_cnt - CNT_W'(ROWS + c))][c] <= w_psum[ROWS-1][c];
          end
          if (r_cnt == CNT_W'(COMPUTE_CYCLES - 1)) begin
            r_state     <= S_WRITE;
            r_cnt       <= '0;
            r_out_wr_en <= 1'b1;
            r_out_addr  <= '0;
            for (int c = 0; c < COLS; c++)
              r_out_data[c*WORD_SIZE +: WORD_SIZE] <= r_out_buf[0][c];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (r_cnt == CNT_W'(ROWS - 1)) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_wr_en <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_out_addr <= r_out_addr + 32'd1;
            for (int c = 0; c < COLS; c++)
              r_out_data[c*WORD_SIZE +: WORD_SIZE] <= r_out_buf[IDX_W'(r_cnt + 1'b1)][c];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BISR_STW_EN
  logic                 r_stw_complete;
  logic [ROWS*COLS-1:0] r_stw_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stw_complete <= 1'b0;
      r_stw_result   <= '1;
    end else if (r_state == S_IDLE && start_fsm) begin
      r_stw_complete <= 1'b0;
    end else if (r_state == S_STW_CHECK) begin
      r_stw_complete <= 1'b1;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          r_stw_result[c*ROWS+r] <= (w_psum[r][c] == WORD_SIZE'(STW_EXPECT));
    end
  end

  assign STW_complete   = r_stw_complete;
  assign STW_result_mat = r_stw_result;
`else
  assign STW_complete   = 1'b1;
  assign STW_result_mat = '1;
`endif

  assign fsm_rdy                   = r_fsm_rdy;
  assign mem_if.mem_addr           = r_mem_addr;
  assign mem_if.mem_wr_en          = 1'b0;
  assign mem_if.output_mem_wr_data = r_out_data;
  assign mem_if.output_mem_addr    = r_out_addr;
  assign mem_if.output_mem_wr_en   = r_out_wr_en;

endmodule

// File: tb/tb_bisr_ws_systolic_core.sv
// tb/tb_bisr_ws_systolic_core.sv - randomized self-checking bench against a plain matrix-product model
module tb_bisr_ws_systolic_core;
  import bisr_core_pkg::*;

  localparam int R   = 4;
  localparam int C   = 4;
  localparam int W   = 16;
  localparam int MPW = C * W;

  logic           clk = 1'b0;
  logic           rst;
  logic           inputs_rdy;
  logic           start_fsm;
  logic           start_matmul;
  logic           fsm_rdy;
  logic           STW_complete;
  logic [R*C-1:0] STW_result_mat;
`ifdef BISR_STW_EN
  logic [R*C*2-1:0] fault_inject_bus;
`endif

  bisr_ws_systolic_core_if #(.MEM_PORT_WIDTH(MPW)) mem_if ();

  bisr_ws_systolic_core #(.ROWS(R), .COLS(C), .WORD_SIZE(W), .MEM_PORT_WIDTH(MPW)) dut (
    .clk              (clk),
    .rst              (rst),
    .inputs_rdy       (inputs_rdy),
    .start_fsm        (start_fsm),
    .start_matmul     (start_matmul),
    .fsm_rdy          (fsm_rdy),
    .STW_complete     (STW_complete),
    .STW_result_mat   (STW_result_mat),
`ifdef BISR_STW_EN
    .fault_inject_bus (fault_inject_bus),
`endif
    .mem_if           (mem_if)
  );

  always #5 clk = ~clk;

  logic [MPW-1:0] in_mem [2*R];
  always @(posedge clk)
    mem_if.mem_rd_data <= (mem_if.mem_addr < 32'(2*R)) ? in_mem[mem_if.mem_addr[2:0]] : '0;

  int n_checks   = 0;
  int n_errors   = 0;
  int n_wr_total = 0;
  always @(negedge clk) if (mem_if.output_mem_wr_en) n_wr_total++;

  int             m_top  [R][C];
  int             m_left [R][R];
  logic [W-1:0]   m_out  [R][C];
  logic           exp_rst_cmpl;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int rand_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic load_and_model();
    longint acc;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) in_mem[r][c*W +: W] = W'(m_top[r][c]);
    for (int i = 0; i < R; i++)
      for (int r = 0; r < R; r++) in_mem[R+i][r*W +: W] = W'(m_left[i][r]);
    for (int i = 0; i < R; i++)
      for (int c = 0; c < C; c++) begin
        acc = 0;
        for (int r = 0; r < R; r++) acc += longint'(m_left[i][r]) * longint'(m_top[r][c]);
        m_out[i][c] = W'(acc);
      end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_val({tag, "_fsm_rdy"},  64'(fsm_rdy), 64'd0);
    chk_val({tag, "_stw_cmpl"}, 64'(STW_complete), 64'(exp_rst_cmpl));
    chk_val({tag, "_stw_mat"},  64'(STW_result_mat), 64'hFFFF);
    chk_val({tag, "_mem_addr"}, 64'(mem_if.mem_addr), 64'd0);
    chk_val({tag, "_wr_en"},    64'(mem_if.output_mem_wr_en), 64'd0);
    chk_val({tag, "_out_addr"}, 64'(mem_if.output_mem_addr), 64'd0);
    chk_val({tag, "_out_data"}, 64'(mem_if.output_mem_wr_data), 64'd0);
  endtask

  task automatic wait_stw_ready(input string tag, input logic [R*C-1:0] exp_mask);
    int waited = 0;
    while (!(STW_complete && fsm_rdy) && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    chk_val({tag, "_cmpl"}, 64'(STW_complete), 64'd1);
    chk_val({tag, "_rdy"},  64'(fsm_rdy), 64'd1);
    chk_val({tag, "_mat"},  64'(STW_result_mat), 64'(exp_mask));
  endtask

  task automatic accept_matmul(input string tag);
    int waited = 0;
    inputs_rdy = 1'b1;
    while (!fsm_rdy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk_val({tag, "_ready"}, 64'(fsm_rdy), 64'd1);
    start_matmul = 1'b1;
    @(negedge clk);
    start_matmul = 1'b0;
    chk_val({tag, "_accepted"}, 64'(fsm_rdy), 64'd0);
  endtask

  task automatic run_matmul(input string tag);
    logic [MPW-1:0] got [R];
    logic [MPW-1:0] exp_row;
    int n_wr    = 0;
    int last_wr = 0;
    for (int i = 0; i < R; i++) got[i] = '0;
    load_and_model();
    accept_matmul(tag);
    for (int k = 1; k <= 32; k++) begin
      if (mem_if.output_mem_wr_en) begin
        if (n_wr < R) begin
          chk_val({tag, "_waddr"}, 64'(mem_if.output_mem_addr), 64'(n_wr));
          got[n_wr] = mem_if.output_mem_wr_data;
        end
        n_wr++;
        last_wr = k;
      end
      @(negedge clk);
    end
    chk_val({tag, "_nwrites"}, 64'(n_wr), 64'(R));
    chk_val({tag, "_latency_ok"}, 64'(last_wr > 0 && last_wr <= 3*R + 2*C + 4), 64'd1);
    for (int i = 0; i < R; i++) begin
      for (int c = 0; c < C; c++) exp_row[c*W +: W] = m_out[i][c];
      chk_val($sformatf("%s_row%0d", tag, i), 64'(got[i]), 64'(exp_row));
    end
  endtask

  task automatic fill_random();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) m_top[r][c] = rand_s16();
    for (int i = 0; i < R; i++)
      for (int r = 0; r < R; r++) m_left[i][r] = rand_s16();
  endtask

  initial begin
    int             wr0;
    logic [R*C-1:0] mask;
`ifdef BISR_STW_EN
    exp_rst_cmpl     = 1'b0;
    fault_inject_bus = '0;
`else
    exp_rst_cmpl     = 1'b1;
`endif
    for (int i = 0; i < 2*R; i++) in_mem[i] = '0;
    rst = 1'b1; inputs_rdy = 1'b0; start_fsm = 1'b0; start_matmul = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");

    rst = 1'b0; start_fsm = 1'b1;
    wait_stw_ready("stw_boot", '1);
    chk_val("boot_no_writes", 64'(n_wr_total), 64'd0);

    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) m_top[r][c] = (r == c) ? 1 : 0;
    for (int i = 0; i < R; i++)
      for (int r = 0; r < R; r++) m_left[i][r] = i * R + r + 1;
    run_matmul("identity");

    fill_random();
    m_top[0] = '{-5, 0, 0, 1};
    m_top[1] = '{4, 8, 6, 2};
    m_top[2] = '{1, 21, 9, 3};
    m_top[3] = '{6, 7, 1, 1};
    m_left[0] = '{9, 4, 2, 1};
    run_matmul("mixed_sign");

    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        m_top[r][c]  = 32'h7FFF;
        m_left[r][c] = 2;
      end
    run_matmul("wrap");

    for (int n = 0; n < 3; n++) begin
      fill_random();
      run_matmul($sformatf("rand%0d", n));
    end

    fill_random();
    load_and_model();
    accept_matmul("abort");
    repeat (11) @(negedge clk);
    wr0 = n_wr_total;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0; start_fsm = 1'b0;
    repeat (30) @(negedge clk);
    chk_val("abort_no_writes", 64'(n_wr_total - wr0), 64'd0);
    start_fsm = 1'b1;
    wait_stw_ready("abort_restart", '1);
    fill_random();
    run_matmul("post_abort");

`ifdef BISR_STW_EN
    rst = 1'b1; start_fsm = 1'b0;
    fault_inject_bus = '0;
    fault_inject_bus[17:16] = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b0; start_fsm = 1'b1;
    mask = '1;
    mask[8] = 1'b0;
    wait_stw_ready("stw_sa1", mask);

    for (int n = 0; n < 3; n++) begin
      int idx = int'($urandom_range(0, R*C-1));
      rst = 1'b1; start_fsm = 1'b0;
      fault_inject_bus = '0;
      fault_inject_bus[2*idx +: 2] = 2'b01;
      repeat (2) @(negedge clk);
      rst = 1'b0; start_fsm = 1'b1;
      mask = '1;
      mask[idx] = 1'b0;
      wait_stw_ready($sformatf("stw_sa0_%0d", idx), mask);
    end

    rst = 1'b1; start_fsm = 1'b0; fault_inject_bus = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; start_fsm = 1'b1;
    wait_stw_ready("stw_clean", '1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
